// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Two-digit multiplexed display scanner with a seat-select button.
//   A prescaler generates a scan tick every SCAN_DIV cycles; each tick flips
//   the active digit. In state mode the display shows {0, state_val}; while the
//   seat button is pressed, and for HOLD_TICKS scan ticks after release, it
//   shows {seat_hi, seat_lo}.
//
//   Optional feature macro: SEG_DEBOUNCE_EN
//     defined   -> button is debounced over DB_TICKS consecutive scan ticks
//     undefined -> synchronized button is used directly
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   state_val  in   [3:0] machine state nibble (state mode, low digit)
//   seat_hi    in   [3:0] seat number high digit
//   seat_lo    in   [3:0] seat number low digit
//   sel_btn    in   raw asynchronous seat-select button
//   digit_nib  out  [3:0] registered nibble for the 7-seg decoder
//   digit_sel  out  active digit, 1 = high, 0 = low
//   seat_mode  out  1 while the seat number is displayed
//   scan_tick  out  one-cycle pulse at each scan slot boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter int DB_TICKS   = 20,
    parameter int HOLD_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state_val,
    input  logic [3:0] seat_hi,
    input  logic [3:0] seat_lo,
    input  logic       sel_btn,
    output logic [3:0] digit_nib,
    output logic       digit_sel,
    output logic       seat_mode,
    output logic       scan_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    // Elaboration-time guard on parameter legality.
    if (SCAN_DIV < 2 || DB_TICKS < 0 || HOLD_TICKS < 0) begin : g_param_illegal
        $error("seg_scan_ctrl: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // Prescaler: 0..SCAN_DIV-1, tick decoded from the terminal count.
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_cnt;

    assign scan_tick = (pre_cnt == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (scan_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------
    logic btn_m;
    logic btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= sel_btn;
            btn_s <= btn_m;
        end
    end

    // ------------------------------------------------------------------
    // Button filter
    // ------------------------------------------------------------------
    logic btn_f;

`ifdef SEG_DEBOUNCE_EN
    localparam int DW     = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
    // A zero/one tick requirement both mean "accept on the first differing tick".
    localparam int DB_LIM = (DB_TICKS > 1) ? DB_TICKS - 1 : 0;

    logic [DW-1:0] db_cnt;

    // db_cnt counts differing scan ticks already seen; the tick that would
    // reach DB_TICKS accepts the new level instead of counting further.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_f  <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_f) begin
            db_cnt <= '0;
        end else if (scan_tick) begin
            if (db_cnt >= DW'(DB_LIM)) begin
                btn_f  <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
`else
    assign btn_f = btn_s;
`endif

    // ------------------------------------------------------------------
    // Display mode FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_STATE = 2'd0,
        S_SEAT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          sel_nxt;
    logic          mode_nxt;
    logic [3:0]    nib_nxt;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        unique case (state)
            S_STATE: begin
                if (btn_f) state_nxt = S_SEAT;
            end
            S_SEAT: begin
                if (!btn_f) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HW'(HOLD_TICKS);
                end
            end
            S_HOLD: begin
                // Re-press wins over expiry so seat_mode never drops.
                if (btn_f) begin
                    state_nxt = S_SEAT;
                end else if (hold_cnt == '0) begin
                    state_nxt = S_STATE;
                end else if (scan_tick) begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_STATE;
                hold_nxt  = '0;
            end
        endcase
    end

    // digit_nib is computed from the post-edge select and mode so that
    // digit_nib, digit_sel and seat_mode all switch on the same edge.
    always_comb begin
        sel_nxt  = digit_sel ^ scan_tick;
        mode_nxt = (state_nxt != S_STATE);
        if (mode_nxt) begin
            nib_nxt = sel_nxt ? seat_hi : seat_lo;
        end else begin
            nib_nxt = sel_nxt ? 4'd0 : state_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_STATE;
            hold_cnt  <= '0;
            seat_mode <= 1'b0;
            digit_sel <= 1'b0;
            digit_nib <= 4'd0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            seat_mode <= mode_nxt;
            digit_sel <= sel_nxt;
            digit_nib <= nib_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Scoreboard bench for seg_scan_ctrl (SCAN_DIV=4, DB_TICKS=3, HOLD_TICKS=2).
//   Each cycle a behavioural model predicts the post-edge outputs and queues
//   them; after the edge the DUT outputs are popped and compared. Directed
//   checks cover reset values, asynchronous reset and the button timing.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIV  = 4;
    localparam int DB   = 3;
    localparam int HOLD = 2;

    logic       gclk = 1'b0;
    logic       rst;
    logic [3:0] state_val;
    logic [3:0] seat_hi;
    logic [3:0] seat_lo;
    logic       sel_btn;
    logic [3:0] digit_nib;
    logic       digit_sel;
    logic       seat_mode;
    logic       scan_tick;

    always #5 gclk = ~gclk;

    seg_scan_ctrl #(
        .SCAN_DIV  (DIV),
        .DB_TICKS  (DB),
        .HOLD_TICKS(HOLD)
    ) dut (
        .clk       (gclk),
        .rst       (rst),
        .state_val (state_val),
        .seat_hi   (seat_hi),
        .seat_lo   (seat_lo),
        .sel_btn   (sel_btn),
        .digit_nib (digit_nib),
        .digit_sel (digit_sel),
        .seat_mode (seat_mode),
        .scan_tick (scan_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d @%0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] nib;
        logic       sel;
        logic       mode;
        logic       tick;
    } exp_t;

    exp_t q[$];

    // ---------------- reference model state ----------------
    int m_pre, m_db, m_st, m_hold;
    bit m_sel, m_s1, m_s2, m_bf, m_mode;

    task automatic model_reset();
        m_pre = 0; m_db = 0; m_st = 0; m_hold = 0;
        m_sel = 0; m_s1 = 0; m_s2 = 0; m_bf = 0; m_mode = 0;
    endtask

    // Predict outputs after the coming edge and queue them.
    task automatic model_push();
        bit   tick, btn, n_sel, n_bf;
        int   n_pre, n_db, n_st, n_hold;
        exp_t e;
        tick  = (m_pre == DIV - 1);
        n_pre = tick ? 0 : m_pre + 1;
        n_sel = m_sel ^ tick;
        n_bf  = m_bf;
        n_db  = m_db;
`ifdef SEG_DEBOUNCE_EN
        btn = m_bf;
        if (m_s2 == m_bf) n_db = 0;
        else if (tick) begin
            if (m_db + 1 >= DB) begin n_bf = m_s2; n_db = 0; end
            else n_db = m_db + 1;
        end
`else
        btn = m_s2;
`endif
        n_st = m_st; n_hold = m_hold;
        case (m_st)
            0: if (btn) n_st = 1;
            1: if (!btn) begin n_st = 2; n_hold = HOLD; end
            default: begin
                if (btn) n_st = 1;
                else if (m_hold == 0) n_st = 0;
                else if (tick) n_hold = m_hold - 1;
            end
        endcase
        e.mode = (n_st != 0);
        e.sel  = n_sel;
        e.nib  = e.mode ? (n_sel ? seat_hi : seat_lo) : (n_sel ? 4'd0 : state_val);
        e.tick = (n_pre == DIV - 1);
        q.push_back(e);
        m_s2 = m_s1; m_s1 = sel_btn;
        m_pre = n_pre; m_sel = n_sel; m_bf = n_bf; m_db = n_db;
        m_st = n_st; m_hold = n_hold; m_mode = e.mode;
    endtask

    int tick_cnt;

    // One clock: inputs are stable (called at negedge), compare #1 after posedge.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge gclk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("nib",  digit_nib, e.nib);
            chk("sel",  digit_sel, e.sel);
            chk("mode", seat_mode, e.mode);
            chk("tick", scan_tick, e.tick);
        end
        if (scan_tick) tick_cnt++;
        @(negedge gclk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_nib"},  digit_nib, 0);
        chk({tag, "_sel"},  digit_sel, 0);
        chk({tag, "_mode"}, seat_mode, 0);
        chk({tag, "_tick"}, scan_tick, 0);
    endtask

    initial begin
        rst       = 1'b1;
        state_val = 4'd5;
        seat_hi   = 4'd2;
        seat_lo   = 4'd8;
        sel_btn   = 1'b0;
        model_reset();
        #1;
        check_zero("rst0");
        repeat (2) @(negedge gclk);
        rst = 1'b0;

        // Idle scan: 24 edges -> ticks on edges 3,7,...,23.
        tick_cnt = 0;
        steps(24);
        chk("idle_ticks", tick_cnt, 6);
        chk("idle_mode", seat_mode, 0);

`ifdef SEG_DEBOUNCE_EN
        // Short press (~2 ticks) must be rejected.
        sel_btn = 1'b1;
        steps(8);
        sel_btn = 1'b0;
        steps(4);
        chk("short_mode", seat_mode, 0);
        steps(16);
        chk("short_mode2", seat_mode, 0);
        // Held press, release, hold expiry.
        sel_btn = 1'b1;
        steps(30);
        chk("held_mode", seat_mode, 1);
        sel_btn = 1'b0;
        steps(40);
        chk("after_hold_mode", seat_mode, 0);
        // Re-press during hold.
        sel_btn = 1'b1;
        steps(30);
        sel_btn = 1'b0;
        steps(17);
        sel_btn = 1'b1;
        steps(30);
        chk("repress_mode", seat_mode, 1);
        sel_btn = 1'b0;
        steps(17);
`else
        // One-cycle pulse: seat_mode rises on the third edge after it.
        sel_btn = 1'b1;
        step();
        sel_btn = 1'b0;
        step();
        chk("pulse_e2_mode", seat_mode, 0);
        step();
        chk("pulse_e3_mode", seat_mode, 1);
        steps(3);
        chk("pulse_hold_mode", seat_mode, 1);
        steps(14);
        chk("pulse_end_mode", seat_mode, 0);
        // Re-press during hold.
        sel_btn = 1'b1;
        steps(6);
        sel_btn = 1'b0;
        steps(4);
        sel_btn = 1'b1;
        steps(6);
        chk("repress_mode", seat_mode, 1);
        sel_btn = 1'b0;
        steps(4);
`endif
        // Asynchronous reset mid-operation (seat/hold display active).
        chk("pre_rst_mode", seat_mode, 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        while (q.size() > 0) void'(q.pop_front());
        model_reset();
        @(negedge gclk);
        rst = 1'b0;
        step();
        chk("resume_sel", digit_sel, 0);
        chk("resume_nib", digit_nib, 5);
        steps(12);

        // Input changes and random button activity.
        for (int i = 0; i < 300; i++) begin
            if ((i % 7) == 0) state_val = 4'($urandom_range(0, 15));
            if ((i % 11) == 0) begin
                seat_hi = 4'($urandom_range(0, 15));
                seat_lo = 4'($urandom_range(0, 15));
            end
            if ((i % 5) == 0) sel_btn = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter DB_TICKS, default 20, number of consecutive scan ticks a button level must be stable before it is accepted.
REQ-003 SHALL have parameter HOLD_TICKS, default 200, number of scan ticks the seat display is held after button release.
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port state_val, input, 4 bits, current machine state nibble to display.
REQ-007 SHALL have port seat_hi, input, 4 bits, seat number high digit.
REQ-008 SHALL have port seat_lo, input, 4 bits, seat number low digit.
REQ-009 SHALL have port sel_btn, input, 1 bit, raw, asynchronous, bouncing seat-select button.
REQ-010 SHALL have port digit_nib, output, 4 bits, nibble for the downstream seven-segment decoder.
REQ-011 SHALL have port digit_sel, output, 1 bit, display enable toggle; 1 = high digit, 0 = low digit.
REQ-012 SHALL have port seat_mode, output, 1 bit, which is 1 while the seat number is displayed.
REQ-013 SHALL have port scan_tick, output, 1 bit, one-cycle pulse at each scan slot boundary.

Function
REQ-014 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; scan_tick SHALL be 1 exactly when the count equals SCAN_DIV-1.
REQ-015 digit_sel SHALL toggle on every clk edge where scan_tick = 1, giving a period of 2*SCAN_DIV cycles.
REQ-016 sel_btn SHALL pass through a 2-flop synchronizer; the synchronizer output is btn_s.
REQ-017 The filtered button btn_f SHALL feed a registered FSM with states S_STATE, S_SEAT and S_HOLD.
- S_STATE: btn_f = 1 -> S_SEAT.
- S_SEAT: btn_f = 0 -> S_HOLD, and the hold counter is loaded with HOLD_TICKS.
- S_HOLD: btn_f = 1 -> S_SEAT (priority over everything else); else, if the hold counter = 0 -> S_STATE; else, on scan_tick, the counter decrements.
REQ-018 With HOLD_TICKS = 0, S_HOLD SHALL exit to S_STATE on the next clk edge.
REQ-019 seat_mode SHALL be 1 in S_SEAT and S_HOLD, and 0 in S_STATE; it changes 1 cycle after btn_f changes.
REQ-020 digit_nib SHALL be registered and computed from the next-cycle values of digit_sel and seat_mode, so digit_nib and digit_sel always change on the same edge:
- state mode: sel = 1 -> 4'd0; sel = 0 -> state_val.
- seat mode: sel = 1 -> seat_hi; sel = 0 -> seat_lo.
REQ-021 Changes on state_val, seat_hi or seat_lo SHALL appear on digit_nib exactly 1 cycle later when the digit that uses them is selected.
REQ-022 If a scan_tick coincides with an FSM transition, the new digit_sel and the new mode SHALL both take effect on that same edge.
REQ-023 All counters SHALL be sized for their parameter maxima and SHALL never overflow or underflow; the hold counter saturates at 0.

Reset
REQ-024 While rst = 1 the block SHALL force, without waiting for clk:
- prescaler = 0, digit_sel = 0, scan_tick = 0;
- digit_nib = 4'd0, seat_mode = 0, FSM = S_STATE;
- synchronizer flops = 0, btn_f = 0, debounce counter = 0, hold counter = 0.
REQ-025 An assertion of rst in mid-operation (any state) SHALL abort immediately, and the block SHALL restart from the reset state on the first edge after release.

Configuration
REQ-026 Macro SEG_DEBOUNCE_EN defined:
- btn_f updates to btn_s only after btn_s differs from btn_f for DB_TICKS consecutive scan ticks;
- any return to agreement clears the debounce counter.
REQ-027 Macro SEG_DEBOUNCE_EN undefined:
- btn_f SHALL equal btn_s with no additional delay;
- the debounce counter SHALL be omitted.

Verification (SCAN_DIV = 4, DB_TICKS = 3, HOLD_TICKS = 2, state_val = 5, seat_hi = 2, seat_lo = 8)
REQ-028 Release rst and idle -> scan_tick is 1 every 4th cycle; digit_sel toggles per tick; digit_nib alternates 0 (sel = 1) and 5 (sel = 0); seat_mode = 0.
REQ-029 SEG_DEBOUNCE_EN defined, sel_btn held high -> seat_mode rises 1 cycle after the 3rd stable scan tick; digit_nib alternates 2 and 8.
REQ-030 SEG_DEBOUNCE_EN defined, sel_btn high for 2 scan ticks then low -> seat_mode stays 0 and digit_nib keeps showing 0/5.
REQ-031 Release after REQ-029 -> display is held for 2 scan ticks and then returns to 0/5; a re-press during S_HOLD returns the FSM to S_SEAT with no gap in seat_mode.
REQ-032 rst asserted during S_HOLD -> outputs are 0 immediately; after release, the display resumes 0/5 from digit_sel = 0.
REQ-033 SEG_DEBOUNCE_EN undefined, sel_btn pulsed high for 1 cycle -> seat_mode = 1 three cycles after the pulse, then follows the HOLD sequence.
